// File: rtl/pulse_level_gen.sv
// Rebuilds level waveforms from single-cycle rise/fall pulses and produces a
// programmable-length one-shot level from a stretch pulse.
module pulse_level_gen #(
    parameter int CNT_W  = 8,
    parameter bit RETRIG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise_pulse,
    input  logic             fall_pulse,
    input  logic             stretch_pulse,
    input  logic [CNT_W-1:0] stretch_len,
    output logic             level,
    output logic             busy,
    output logic             done,
    output logic             conflict
);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HOLD = 2'd1,
        ST_SHOT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             conflict_q, conflict_d;

    logic             len_nonzero;
    logic             both_pulses;

    assign len_nonzero = (stretch_len != '0);
    assign both_pulses = rise_pulse & fall_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOW;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    // A rise+fall collision is dropped as a request, but a running one-shot
    // still advances that cycle so its length is not disturbed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        conflict_d = both_pulses;

        unique case (state_q)
            ST_LOW: begin
                if (!both_pulses) begin
                    if (fall_pulse) begin
                        state_d = ST_LOW;
                    end else if (rise_pulse) begin
                        state_d = ST_HOLD;
                    end else if (stretch_pulse && len_nonzero) begin
                        state_d = ST_SHOT;
                        cnt_d   = stretch_len;
                    end
                end
            end

            ST_HOLD: begin
                if (!both_pulses && fall_pulse) begin
                    state_d = ST_LOW;
                end
            end

            ST_SHOT: begin
                if (!both_pulses && fall_pulse) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (!both_pulses && rise_pulse) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (!both_pulses && stretch_pulse && RETRIG && len_nonzero) begin
                    cnt_d = stretch_len;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level    = (state_q != ST_LOW);
    assign busy     = (state_q == ST_SHOT);
    assign done     = done_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_pulse_level_gen.sv
// Drives identical random/directed pulse traffic into a retriggerable and a
// non-retriggerable instance and scoreboards both against an end-time model.
module tb_pulse_level_gen;

    logic       clk;
    logic       rst;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       stretch_pulse;
    logic [7:0] stretch_len;

    logic level_r1, busy_r1, done_r1, conflict_r1;
    logic level_r0, busy_r0, done_r0, conflict_r0;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected outputs, {level,busy,done,conflict} for RETRIG=1 then RETRIG=0.
    logic [7:0] exp_q[$];

    // Model state: held level, one-shot active, and the absolute edge it ends on.
    bit m_hold[2];
    bit m_shot[2];
    int m_end[2];
    int edge_idx = 0;

    pulse_level_gen #(.CNT_W(8), .RETRIG(1'b1)) dut_r1 (
        .clk          (clk),
        .rst          (rst),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .stretch_pulse(stretch_pulse),
        .stretch_len  (stretch_len),
        .level        (level_r1),
        .busy         (busy_r1),
        .done         (done_r1),
        .conflict     (conflict_r1)
    );

    pulse_level_gen #(.CNT_W(8), .RETRIG(1'b0)) dut_r0 (
        .clk          (clk),
        .rst          (rst),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .stretch_pulse(stretch_pulse),
        .stretch_len  (stretch_len),
        .level        (level_r0),
        .busy         (busy_r0),
        .done         (done_r0),
        .conflict     (conflict_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_edge(input int k, input bit retrig,
                                              input bit r, input bit f, input bit s,
                                              input int len, input bit rs);
        bit touched;
        bit was_shot;
        bit d;
        bit c;
        touched  = 1'b0;
        was_shot = m_shot[k];
        d = 1'b0;
        c = 1'b0;
        if (rs) begin
            m_hold[k] = 1'b0;
            m_shot[k] = 1'b0;
        end else begin
            if (r && f) begin
                c = 1'b1;
            end else if (f) begin
                m_hold[k] = 1'b0;
                m_shot[k] = 1'b0;
                touched   = 1'b1;
            end else if (r) begin
                m_hold[k] = 1'b1;
                m_shot[k] = 1'b0;
                touched   = 1'b1;
            end else if (s && len != 0 && !m_hold[k] && (!was_shot || retrig)) begin
                m_shot[k] = 1'b1;
                m_end[k]  = edge_idx + len;
                touched   = 1'b1;
            end
            if (was_shot && !touched && edge_idx == m_end[k]) begin
                m_shot[k] = 1'b0;
                d = 1'b1;
            end
        end
        return {m_hold[k] | m_shot[k], m_shot[k], d, c};
    endfunction

    task automatic apply_stimulus(input bit r, input bit f, input bit s,
                                  input int len, input bit rs);
        logic [3:0] e1;
        logic [3:0] e0;
        @(negedge clk);
        rst           = rs;
        rise_pulse    = r;
        fall_pulse    = f;
        stretch_pulse = s;
        stretch_len   = 8'(len);
        e1 = model_edge(0, 1'b1, r, f, s, len, rs);
        e0 = model_edge(1, 1'b0, r, f, s, len, rs);
        exp_q.push_back({e1, e0});
        edge_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_output(input logic [7:0] exp);
        logic [3:0] got1;
        logic [3:0] got0;
        got1 = {level_r1, busy_r1, done_r1, conflict_r1};
        got0 = {level_r0, busy_r0, done_r0, conflict_r0};
        tests_run += 2;
        if (got1 !== exp[7:4]) begin
            tests_failed++;
            $display("[TB] FAIL outs_retrig1 t=%0t lvl/busy/done/conf got %b expected %b",
                     $time, got1, exp[7:4]);
        end
        if (got0 !== exp[3:0]) begin
            tests_failed++;
            $display("[TB] FAIL outs_retrig0 t=%0t lvl/busy/done/conf got %b expected %b",
                     $time, got0, exp[3:0]);
        end
    endtask

    // Monitor: every clock the DUTs present a fresh output set, so one
    // expectation is retired per edge, sampled just after it.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        int len;
        int wait_cnt;
        rst           = 1'b1;
        rise_pulse    = 1'b0;
        fall_pulse    = 1'b0;
        stretch_pulse = 1'b0;
        stretch_len   = 8'd0;

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Held level from rise/fall
        idle(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(4);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(3);

        // Plain one-shot, then retrigger
        apply_stimulus(1'b0, 1'b0, 1'b1, 5, 1'b0);
        idle(8);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4, 1'b0);
        idle(1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4, 1'b0);
        idle(8);

        // Abort by fall, zero-length stretch, length one
        apply_stimulus(1'b0, 1'b0, 1'b1, 10, 1'b0);
        idle(2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle(3);

        // Conflicts in LOW, mid one-shot, and on the expiring edge
        apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        idle(1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 6, 1'b0);
        idle(1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 9, 1'b0);
        idle(6);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle(2);
        apply_stimulus(1'b1, 1'b1, 1'b0, 0, 1'b0);
        idle(2);

        // Rise during one-shot, stretch while held
        apply_stimulus(1'b0, 1'b0, 1'b1, 8, 1'b0);
        idle(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle(5);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(1);

        // Maximum length
        apply_stimulus(1'b0, 1'b0, 1'b1, 255, 1'b0);
        idle(258);

        // Reset in the middle of a one-shot, then rise
        apply_stimulus(1'b0, 1'b0, 1'b1, 20, 1'b0);
        idle(3);
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // Back-to-back stretches every cycle
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 3, 1'b0);
        idle(5);

        for (int i = 0; i < 3000; i++) begin
            len = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 12));
            apply_stimulus($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                           $urandom_range(0, 9) == 0, len,
                           $urandom_range(0, 499) == 0);
        end
        idle(3);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 8) begin
            @(posedge clk);
            #2;
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain pending got %0d expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
